// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped data cache: FSM states and
// address field geometry used by both the CPU side and the cache.
package data_cache_pkg;
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOC_REQ,
    ALLOC_WAIT
  } state_t;

  // Tag width left over once byte, word and index fields are carved out.
  function automatic int tag_width(input int num_sets, input int line_words);
    return ADDR_W - BYTE_OFF_W - $clog2(line_words) - $clog2(num_sets);
  endfunction
endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data storage: one combinational read port, one
// synchronous write port. Reset clears only the valid and dirty bits.
module cache_line_store #(
  parameter int NUM_SETS = 16,
  parameter int TAG_W    = 24,
  parameter int LINE_W   = 128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_SETS)-1:0] rd_index,
  output logic                        rd_valid,
  output logic                        rd_dirty,
  output logic [TAG_W-1:0]            rd_tag,
  output logic [LINE_W-1:0]           rd_data,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_SETS)-1:0] wr_index,
  input  logic [TAG_W-1:0]            wr_tag,
  input  logic [LINE_W-1:0]           wr_data,
  input  logic                        wr_dirty
);
  logic [NUM_SETS-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a single
// outstanding request and a line-granular backing-memory port.
module data_cache import data_cache_pkg::*; #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [WORD_W-1:0]            req_wdata,
  output logic                         is_ready,
  output logic                         resp_valid,
  output logic [WORD_W-1:0]            resp_rdata,
  output logic                         resp_hit,
  output logic                         mem_req_valid,
  output logic                         mem_req_write,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [WORD_W*LINE_WORDS-1:0] mem_req_wdata,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  input  logic [WORD_W*LINE_WORDS-1:0] mem_resp_rdata,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = BYTE_OFF_W + WSEL_W;
  localparam int TAG_W  = tag_width(NUM_SETS, LINE_WORDS);
  localparam int LINE_W = WORD_W * LINE_WORDS;

  state_t              state, next;
  logic                write_q, missed_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [31:0]         hit_q, miss_q;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag, line_tag, wr_tag;
  logic [WSEL_W-1:0]   wsel;
  logic                line_valid, line_dirty, hit, wr_en, wr_dirty;
  logic [LINE_W-1:0]   line_data, merged, wr_data;
  logic [WORD_W-1:0]   sel_word;
  logic                unused_addr_bits;

  assign idx  = addr_q[OFF_W +: IDX_W];
  assign tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign wsel = addr_q[BYTE_OFF_W +: WSEL_W];
  assign hit  = line_valid && (line_tag == tag);
  assign unused_addr_bits = ^addr_q[BYTE_OFF_W-1:0];

  cache_line_store #(.NUM_SETS(NUM_SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_index (idx),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_index (idx),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data),
    .wr_dirty (wr_dirty)
  );

  // Word select for loads and store-data merge into the current line.
  always_comb begin
    sel_word = '0;
    merged   = line_data;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (wsel == WSEL_W'(i)) begin
        sel_word = line_data[i*WORD_W +: WORD_W];
        merged[i*WORD_W +: WORD_W] = wdata_q;
      end
    end
  end

  always_comb begin
    next          = state;
    is_ready      = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_hit      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    wr_en         = 1'b0;
    wr_tag        = tag;
    wr_data       = merged;
    wr_dirty      = 1'b1;
    case (state)
      IDLE: begin
        is_ready = 1'b1;
        if (req_valid) next = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_hit   = !missed_q;
          resp_rdata = write_q ? '0 : sel_word;
          wr_en      = write_q;
          next       = IDLE;
        end else if (line_valid && line_dirty) begin
          next = WRITEBACK;
        end else begin
          next = ALLOC_REQ;
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {line_tag, idx, OFF_W'(0)};
        mem_req_wdata = line_data;
        if (mem_req_ready) next = ALLOC_REQ;
      end
      ALLOC_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag, idx, OFF_W'(0)};
        if (mem_req_ready) next = ALLOC_WAIT;
      end
      ALLOC_WAIT: begin
        if (mem_resp_valid) begin
          wr_en    = 1'b1;
          wr_data  = mem_resp_rdata;
          wr_dirty = 1'b0;
          next     = COMPARE;
        end
      end
      default: next = IDLE;
    endcase
    // Reset silences every output and aborts any in-flight transaction.
    if (reset) begin
      next          = IDLE;
      is_ready      = 1'b0;
      resp_valid    = 1'b0;
      resp_rdata    = '0;
      resp_hit      = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      wr_en         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      missed_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state <= next;
      if (state == IDLE && req_valid) begin
        write_q  <= req_write;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        missed_q <= 1'b0;
      end
      if (state == ALLOC_WAIT && mem_resp_valid) missed_q <= 1'b1;
      if (resp_valid) begin
        if (missed_q) miss_q <= miss_q + 32'd1;
        else          hit_q  <= hit_q + 32'd1;
      end
    end
  end

  assign hit_count  = reset ? '0 : hit_q;
  assign miss_count = reset ? '0 : miss_q;
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter NUM_SETS, 16, number of direct-mapped sets (power of two).
REQ-002 Parameter LINE_WORDS, 4, 32-bit words per line (line = 128 bits).
REQ-003 clk input 1, clock; all state updates on rising edge.
REQ-004 reset input 1, synchronous, active-high.
REQ-005 req_valid input 1, CPU-side memory request present.
REQ-006 req_write input 1, 1 = store, 0 = load.
REQ-007 req_addr input 32, byte address; bits [1:0] ignored, [3:2] word, [7:4] index, [31:8] tag.
REQ-008 req_wdata input 32, store data.
REQ-009 is_ready output 1, cache can accept a request this cycle.
REQ-010 resp_valid output 1, one-cycle pulse completing the accepted request.
REQ-011 resp_rdata output 32, load data, valid only with resp_valid on a load.
REQ-012 resp_hit output 1, with resp_valid: 1 if the first lookup hit.
REQ-013 mem_req_valid output 1, backing-memory request.
REQ-014 mem_req_write output 1, 1 = line writeback, 0 = line fill.
REQ-015 mem_req_addr output 32, line-aligned address (bits [3:0] = 0).
REQ-016 mem_req_wdata output 128, writeback line; word 0 in bits [31:0].
REQ-017 mem_req_ready input 1, memory accepts request this cycle.
REQ-018 mem_resp_valid input 1, fill data present (reads only).
REQ-019 mem_resp_rdata input 128, fill line.
REQ-020 hit_count, miss_count output 32 each, completed-access statistics.

Function
REQ-021 States: IDLE, COMPARE, WRITEBACK, ALLOC_REQ, ALLOC_WAIT.
REQ-022 is_ready = 1 only in IDLE; request accepted when req_valid && is_ready; req_write/addr/wdata latched at acceptance; IDLE -> COMPARE.
REQ-023 req_valid outside IDLE is ignored; no queueing.
REQ-024 COMPARE hit (valid && tag match): load returns selected word; store writes word and sets dirty; resp_valid=1 that cycle; -> IDLE. Hit latency = 1 cycle after acceptance.
REQ-025 COMPARE miss, line clean or invalid -> ALLOC_REQ; miss, valid && dirty -> WRITEBACK.
REQ-026 WRITEBACK: mem_req_valid=1, write=1, addr={stored tag,index,4'b0}, wdata=line; held stable until mem_req_ready; on handshake -> ALLOC_REQ.
REQ-027 ALLOC_REQ: mem_req_valid=1, write=0, addr={req tag,index,4'b0}; held until mem_req_ready; -> ALLOC_WAIT.
REQ-028 ALLOC_WAIT: mem_resp_valid ignored in any other state; on mem_resp_valid write line, tag, valid=1, dirty=0; -> COMPARE (retried lookup now hits).
REQ-029 resp_hit = 0 for any request that passed through ALLOC_WAIT; miss_count increments once per such request at its resp_valid, hit_count once per first-lookup hit.
REQ-030 Counters wrap modulo 2^32.
REQ-031 mem_req_valid = 0 in IDLE, COMPARE, ALLOC_WAIT; resp_valid = 0 outside COMPARE.
REQ-032 resp_rdata = 0 when resp_valid = 0 or on store responses.
REQ-033 Store miss is write-allocate: fill, then store merges into filled line, dirty=1.

Reset
REQ-034 Reset clears all valid and dirty bits, state -> IDLE, counters -> 0; all outputs 0 while reset is high (is_ready = 0 during reset, 1 the cycle after).
REQ-035 Reset mid-operation aborts any pending request and memory transaction; dirty data is discarded; no response issued.

Structure
REQ-036 State encoding, address field widths/offsets, and line width belong in shared define header cache_defs.v, used by CPU and cache.
REQ-037 Tag/valid/dirty/data storage is one sub-module cache_line_store (one read port, one write port, synchronous write, combinational read, reset clears valid/dirty only).

Verification
REQ-038 Cold load 0x0000_0104, memory returns line {4,3,2,1} after 3-cycle delay -> mem read addr 0x100, resp_rdata=2, resp_hit=0, miss_count=1.
REQ-039 Repeat load 0x108 -> resp_valid exactly 1 cycle after acceptance, rdata=3, resp_hit=1, hit_count=1, no mem_req_valid.
REQ-040 Store 0xDEAD to 0x100 then load 0x1100 (same index 0) -> writeback addr 0x100 with word0=0xDEAD, then fill addr 0x1100.
REQ-041 mem_req_ready held low 5 cycles during WRITEBACK -> mem_req_addr/wdata stable all 5 cycles; req_valid pulses ignored, is_ready=0.
REQ-042 Reset asserted in ALLOC_WAIT, then stale mem_resp_valid -> no resp_valid, state IDLE, all lines invalid, counters 0.
